irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller with a five-register special-register window.
// Optional build macro IRQ_CTRL_PRIO_ROTATE_EN selects rotating instead of fixed priority.
module irq_ctrl #(
   parameter logic [15:0] SR_BASE = 16'h0040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  irq_src,
   input  logic        sr_ie,
   input  logic [15:0] sr_sel,
   input  logic [15:0] sr_in,
   output logic [15:0] sr_out,
   input  logic        irq_ack,
   output logic        irq_out,
   output logic        in_service
);

   localparam logic [15:0] ADDR_MASK = SR_BASE;
   localparam logic [15:0] ADDR_PEND = SR_BASE + 16'd1;
   localparam logic [15:0] ADDR_VEC  = SR_BASE + 16'd2;
   localparam logic [15:0] ADDR_MODE = SR_BASE + 16'd3;
   localparam logic [15:0] ADDR_EOI  = SR_BASE + 16'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  src_q;
   logic [7:0]  mask;
   logic [7:0]  mode;
   logic [7:0]  pend_edge;
   logic [7:0]  pend;
   logic [7:0]  eligible;
   logic [7:0]  edge_set;
   logic [7:0]  clr_w1c;
   logic [7:0]  clr_ack;
   logic [2:0]  vec;
   logic [2:0]  vec_next;
   logic [2:0]  winner;
   logic [2:0]  search_start;
   logic [2:0]  idx;
   logic        found;
   logic        eoi_wr;
   logic        unused_sr_in;

   assign unused_sr_in = ^sr_in[15:8];

   // Level sources track the registered line directly; only edge sources keep sticky state.
   assign pend     = (pend_edge & ~mode) | (src_q & mode);
   assign eligible = pend & mask;
   assign edge_set = irq_src & ~src_q & ~mode;
   assign clr_w1c  = (sr_ie && (sr_sel == ADDR_PEND)) ? sr_in[7:0] : 8'h00;
   assign clr_ack  = (state == REQ && irq_ack) ? (8'h01 << vec) : 8'h00;
   assign eoi_wr   = sr_ie && (sr_sel == ADDR_EOI);

`ifdef IRQ_CTRL_PRIO_ROTATE_EN
   logic [2:0] prio_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         prio_ptr <= 3'd0;
      else if (state == SERVICE && eoi_wr)
         prio_ptr <= vec + 3'd1;
   end

   assign search_start = prio_ptr;
`else
   assign search_start = 3'd0;
`endif

   always_comb begin
      found  = 1'b0;
      winner = 3'd0;
      idx    = 3'd0;
      for (int k = 0; k < 8; k++) begin
         idx = search_start + 3'(k);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Set wins over any clear landing on the same bit in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q     <= 8'h00;
         mask      <= 8'h00;
         mode      <= 8'h00;
         pend_edge <= 8'h00;
      end else begin
         src_q     <= irq_src;
         pend_edge <= ((pend_edge & ~(clr_w1c | clr_ack)) | edge_set) & ~mode;
         if (sr_ie && sr_sel == ADDR_MASK)
            mask <= sr_in[7:0];
         if (sr_ie && sr_sel == ADDR_MODE)
            mode <= sr_in[7:0];
      end
   end

   always_comb begin
      state_next = state;
      vec_next   = vec;
      case (state)
         IDLE: begin
            if (eligible != 8'h00) begin
               state_next = REQ;
               vec_next   = winner;
            end
         end
         REQ: begin
            if (irq_ack)
               state_next = SERVICE;
         end
         SERVICE: begin
            if (eoi_wr)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         vec     <= 3'd0;
         irq_out <= 1'b0;
      end else begin
         state   <= state_next;
         vec     <= vec_next;
         irq_out <= (state_next == REQ);
      end
   end

   assign in_service = (state == SERVICE);

   always_comb begin
      sr_out = 16'h0000;
      if (sr_sel == ADDR_MASK)
         sr_out = {8'h00, mask};
      else if (sr_sel == ADDR_PEND)
         sr_out = {8'h00, pend};
      else if (sr_sel == ADDR_VEC)
         sr_out = {in_service, 12'h000, vec};
      else if (sr_sel == ADDR_MODE)
         sr_out = {8'h00, mode};
   end

endmodule
